// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use hazard unit for a 5-stage MIPS/DLX pipeline.
// It keeps a private shadow of the destination register and RegWrite for the
// MEM and WB stages. From the ID-stage sources it produces two things:
// registered EX operand selects, and a combinational one-bubble load-use stall.
module forwarding_hazard_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_WB_register,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    output logic [1:0]       sel_a_forwarding,
    output logic [1:0]       sel_b_forwarding,
    output logic             stall,
    output logic             flush_ex,
    output logic [CNT_W-1:0] stall_count
);

    // Select encodings seen by the EX-stage operand muxes.
    localparam logic [1:0] SEL_BUS   = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;

    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [REG_W-1:0] mem_dest_r;
    logic             mem_rw_r;
    logic [REG_W-1:0] wb_dest_r;
    logic             wb_rw_r;
    logic [1:0]       sel_a_r;
    logic [1:0]       sel_b_r;
    logic [CNT_W-1:0] stall_count_r;

    logic             stall_s;
    logic [1:0]       sel_a_nxt_s;
    logic [1:0]       sel_b_nxt_s;

    // Pick the operand source for one ID-stage register read.
    // The newest producer wins. A WB-stage producer is deliberately not
    // forwarded, because the register file writes in the first half-cycle
    // and reads in the second, so the bus already carries that value.
    function automatic logic [1:0] fwd_sel(
        input logic             src_used,
        input logic [REG_W-1:0] src,
        input logic             hazard,
        input logic [REG_W-1:0] ex_dest,
        input logic             ex_rw,
        input logic [REG_W-1:0] mem_dest,
        input logic             mem_rw,
        input logic [REG_W-1:0] wb_dest,
        input logic             wb_rw
    );
        logic [1:0] sel;
        sel = SEL_BUS;
        if (!src_used || hazard || (src == REG_ZERO)) begin
            sel = SEL_BUS;
        end else if (ex_rw && (ex_dest == src)) begin
            sel = SEL_EXMEM;
        end else if (mem_rw && (mem_dest == src)) begin
            sel = SEL_MEMWB;
        end else if (wb_rw && (wb_dest == src)) begin
            sel = SEL_BUS;
        end else begin
            sel = SEL_BUS;
        end
        return sel;
    endfunction

    // Detect a load-use hazard and compute the next selects.
    // An instruction that will be held in ID receives no forwarding this cycle.
    always_comb begin
        stall_s     = 1'b0;
        sel_a_nxt_s = SEL_BUS;
        sel_b_nxt_s = SEL_BUS;
        if (id_valid && ex_mem_read && ex_reg_write && (ex_WB_register != REG_ZERO) &&
            ((ex_WB_register == id_rs) || (id_uses_rt && (ex_WB_register == id_rt)))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
        sel_a_nxt_s = fwd_sel(id_valid, id_rs, stall_s, ex_WB_register, ex_reg_write,
                              mem_dest_r, mem_rw_r, wb_dest_r, wb_rw_r);
        sel_b_nxt_s = fwd_sel(id_valid && id_uses_rt, id_rt, stall_s, ex_WB_register,
                              ex_reg_write, mem_dest_r, mem_rw_r, wb_dest_r, wb_rw_r);
    end

    // Advance the destination shadows and register the selects and stall count.
    // The shadows advance even while stalled, because the ID/EX bubble keeps moving.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_dest_r    <= REG_ZERO;
            mem_rw_r      <= 1'b0;
            wb_dest_r     <= REG_ZERO;
            wb_rw_r       <= 1'b0;
            sel_a_r       <= SEL_BUS;
            sel_b_r       <= SEL_BUS;
            stall_count_r <= {CNT_W{1'b0}};
        end else begin
            mem_dest_r <= ex_WB_register;
            mem_rw_r   <= ex_reg_write;
            wb_dest_r  <= mem_dest_r;
            wb_rw_r    <= mem_rw_r;
            sel_a_r    <= sel_a_nxt_s;
            sel_b_r    <= sel_b_nxt_s;
            if (stall_s && (stall_count_r != CNT_MAX)) begin
                stall_count_r <= stall_count_r + CNT_ONE;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign sel_a_forwarding = sel_a_r;
    assign sel_b_forwarding = sel_b_r;
    assign stall            = stall_s;
    assign flush_ex         = stall_s;
    assign stall_count      = stall_count_r;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Self-checking bench for forwarding_hazard_unit.
// It runs directed pipeline scenarios and then random traffic, and checks the
// DUT against a reference model of the in-flight instructions.
module tb_forwarding_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [4:0]  ex_WB_register;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [1:0]  sel_a_forwarding;
    logic [1:0]  sel_b_forwarding;
    logic        stall;
    logic        flush_ex;
    logic [15:0] stall_count;

    int vecs = 0;
    int errs = 0;

    // Reference model state: the instruction that sat in EX one cycle ago, the expected registered outputs, and the stall count.
    int m_mem_dest;
    bit m_mem_rw;
    int m_sel_a;
    int m_sel_b;
    int m_cnt;

    forwarding_hazard_unit #(.REG_W(5), .CNT_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_valid         (id_valid),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .ex_WB_register   (ex_WB_register),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .sel_a_forwarding (sel_a_forwarding),
        .sel_b_forwarding (sel_b_forwarding),
        .stall            (stall),
        .flush_ex         (flush_ex),
        .stall_count      (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Load-use rule: the loaded register is needed by the instruction in ID.
    function automatic bit model_stall(bit v, int rs, int rt, bit urt, int exd, bit exrw, bit exmr);
        return v && exmr && exrw && (exd != 0) && ((exd == rs) || (urt && (exd == rt)));
    endfunction

    // Forwarding source for one operand, taking the youngest producer of the register.
    function automatic int model_sel(bit used, int r, bit stl, int exd, bit exrw, int memd, bit memrw);
        if (!used || stl || r == 0) return 0;
        if (exrw && exd == r) return 1;
        if (memrw && memd == r) return 2;
        return 0;
    endfunction

    // One clock cycle: apply the inputs, then check stall.
    // After the edge, check the registered outputs against the model.
    task automatic step(input bit r, input bit v, input int rs, input int rt, input bit urt,
                        input int exd, input bit exrw, input bit exmr);
        bit s;
        int na, nb;
        reset          = r;
        id_valid       = v;
        id_rs          = rs[4:0];
        id_rt          = rt[4:0];
        id_uses_rt     = urt;
        ex_WB_register = exd[4:0];
        ex_reg_write   = exrw;
        ex_mem_read    = exmr;
        #1;
        s = model_stall(v, rs, rt, urt, exd, exrw, exmr);
        chk("stall", int'(stall), int'(s));
        chk("flush_ex", int'(flush_ex), int'(s));
        na = model_sel(v, rs, s, exd, exrw, m_mem_dest, m_mem_rw);
        nb = model_sel(v && urt, rt, s, exd, exrw, m_mem_dest, m_mem_rw);
        @(posedge clk);
        if (r) begin
            m_mem_dest = 0; m_mem_rw = 1'b0; m_sel_a = 0; m_sel_b = 0; m_cnt = 0;
        end else begin
            m_mem_dest = exd; m_mem_rw = exrw; m_sel_a = na; m_sel_b = nb;
            if (s && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
        #1;
        chk("sel_a", int'(sel_a_forwarding), m_sel_a);
        chk("sel_b", int'(sel_b_forwarding), m_sel_b);
        chk("stall_count", int'(stall_count), m_cnt);
    endtask

    task automatic bubble();
        step(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        m_mem_dest = 0; m_mem_rw = 1'b0; m_sel_a = 0; m_sel_b = 0; m_cnt = 0;

        // Reset state.
        step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        chk("rst_sel_a", int'(sel_a_forwarding), 0);
        chk("rst_sel_b", int'(sel_b_forwarding), 0);
        chk("rst_cnt", int'(stall_count), 0);

        // 1: add $3,$1,$2 ; sub $4,$3,$5
        step(1'b0, 1'b1, 1, 2, 1'b1, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3, 5, 1'b1, 3, 1'b1, 1'b0);
        chk("t1_sel_a", int'(sel_a_forwarding), 1);
        chk("t1_sel_b", int'(sel_b_forwarding), 0);
        bubble(); bubble();

        // 2: add $3 ; nop ; or $6,$7,$3
        step(1'b0, 1'b1, 0, 0, 1'b1, 3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 7, 3, 1'b1, 0, 1'b0, 1'b0);
        chk("t2_sel_a", int'(sel_a_forwarding), 0);
        chk("t2_sel_b", int'(sel_b_forwarding), 2);
        bubble(); bubble();

        // 3: lw $8,0($9) ; add $10,$8,$8
        chk("t3_cnt0", int'(stall_count), 0);
        step(1'b0, 1'b1, 8, 8, 1'b1, 8, 1'b1, 1'b1);
        chk("t3_cnt1", int'(stall_count), 1);
        step(1'b0, 1'b1, 8, 8, 1'b1, 0, 1'b0, 1'b0);
        chk("t3_stall_drop", int'(stall), 0);
        chk("t3_sel_a", int'(sel_a_forwarding), 2);
        chk("t3_sel_b", int'(sel_b_forwarding), 2);
        chk("t3_cnt_hold", int'(stall_count), 1);
        bubble(); bubble();

        // 4: add $2 ; add $2 ; sub $5,$2,$2
        step(1'b0, 1'b1, 1, 1, 1'b1, 2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 2, 2, 1'b1, 2, 1'b1, 1'b0);
        chk("t4_sel_a", int'(sel_a_forwarding), 1);
        chk("t4_sel_b", int'(sel_b_forwarding), 1);
        bubble(); bubble();

        // 5: writes to $0, and an rt that is not read
        step(1'b0, 1'b1, 0, 0, 1'b1, 0, 1'b1, 1'b0);
        chk("t5_sel_a", int'(sel_a_forwarding), 0);
        chk("t5_sel_b", int'(sel_b_forwarding), 0);
        step(1'b0, 1'b1, 3, 7, 1'b0, 7, 1'b1, 1'b1);
        chk("t5_no_stall_rt", int'(stall_count), 1);
        step(1'b0, 1'b1, 7, 3, 1'b0, 7, 1'b1, 1'b1);
        chk("t5_stall_rs", int'(stall_count), 2);
        bubble(); bubble();

        // Random traffic over a small register range to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) != 0),
                 $urandom_range(0, 5), $urandom_range(0, 5),
                 $urandom_range(0, 1),
                 $urandom_range(0, 5),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0));
        end

        // 6: Saturate the stall counter, then reset while a stall is active.
        step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 65539; i++) begin
            step(1'b0, 1'b1, 4, 4, 1'b1, 4, 1'b1, 1'b1);
        end
        chk("t6_saturated", int'(stall_count), 65535);
        step(1'b1, 1'b1, 4, 4, 1'b1, 4, 1'b1, 1'b1);
        chk("t6_rst_cnt", int'(stall_count), 0);
        chk("t6_rst_sel_a", int'(sel_a_forwarding), 0);
        chk("t6_rst_sel_b", int'(sel_b_forwarding), 0);
        step(1'b0, 1'b1, 4, 4, 1'b1, 0, 1'b0, 1'b0);
        chk("t6_post_stall", int'(stall), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
